// File: rtl/arb_mux2x1_if.sv
// Valid/ready bundle for the 2:1 round-robin merge: two source streams in,
// one tagged output stream out.
interface arb_mux2x1_if #(
  parameter int unsigned DATA_W = 64
);

  logic              s0_valid;
  logic [DATA_W-1:0] s0_data;
  logic              s0_last;
  logic              s0_ready;

  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic              s1_last;
  logic              s1_ready;

  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              m_sel;
  logic              m_ready;

  // Merge side: accepts both source streams, drives the output stream.
  modport slave (
    input  s0_valid, s0_data, s0_last,
    output s0_ready,
    input  s1_valid, s1_data, s1_last,
    output s1_ready,
    output m_valid, m_data, m_last, m_sel,
    input  m_ready
  );

  // Producer/consumer side.
  modport master (
    output s0_valid, s0_data, s0_last,
    input  s0_ready,
    output s1_valid, s1_data, s1_last,
    input  s1_ready,
    input  m_valid, m_data, m_last, m_sel,
    output m_ready
  );

endinterface

// File: rtl/arb_mux2x1.sv
// 2:1 round-robin stream merge with a single registered output slot.
// Optional packet lock enabled by defining ARB_MUX2X1_LOCK_EN.
module arb_mux2x1 #(
  parameter int unsigned DATA_W   = 64,
  parameter bit          PRIO_RST = 1'b0
) (
  input logic         clk,
  input logic         rst_n,
  arb_mux2x1_if.slave bus
);

  logic              load_en;
  logic              grant0;
  logic              grant1;
  logic              acc0;
  logic              acc1;

  logic              valid_q;
  logic              valid_d;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;
  logic              last_q;
  logic              last_d;
  logic              sel_q;
  logic              sel_d;
  logic              ptr_q;
  logic              ptr_d;
`ifdef ARB_MUX2X1_LOCK_EN
  logic              lock_q;
  logic              lock_d;
  logic              lsrc_q;
  logic              lsrc_d;
`endif

  // Slot can take a beat when empty or being drained this cycle.
  assign load_en = ~valid_q | bus.m_ready;

  always_comb begin : grant_logic
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (bus.s0_valid & bus.s1_valid) begin
      grant0 = ~ptr_q;
      grant1 = ptr_q;
    end else begin
      grant0 = bus.s0_valid;
      grant1 = bus.s1_valid;
    end
`ifdef ARB_MUX2X1_LOCK_EN
    // An open packet owns the slot even while its source is idle.
    if (lock_q) begin
      grant0 = ~lsrc_q;
      grant1 = lsrc_q;
    end
`endif
  end

  assign bus.s0_ready = load_en & grant0;
  assign bus.s1_ready = load_en & grant1;
  assign acc0         = bus.s0_valid & bus.s0_ready;
  assign acc1         = bus.s1_valid & bus.s1_ready;

  always_comb begin : next_state
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
`ifdef ARB_MUX2X1_LOCK_EN
    lock_d  = lock_q;
    lsrc_d  = lsrc_q;
`endif
    if (acc0 | acc1) begin
      valid_d = 1'b1;
      data_d  = acc1 ? bus.s1_data : bus.s0_data;
      last_d  = acc1 ? bus.s1_last : bus.s0_last;
      sel_d   = acc1;
`ifdef ARB_MUX2X1_LOCK_EN
      // Priority moves only when a packet closes; otherwise hold the source.
      if (last_d) begin
        ptr_d  = ~acc1;
        lock_d = 1'b0;
      end else begin
        lock_d = 1'b1;
        lsrc_d = acc1;
      end
`else
      ptr_d   = ~acc1;
`endif
    end else if (load_en) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      sel_q   <= 1'b0;
      ptr_q   <= PRIO_RST;
`ifdef ARB_MUX2X1_LOCK_EN
      lock_q  <= 1'b0;
      lsrc_q  <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
`ifdef ARB_MUX2X1_LOCK_EN
      lock_q  <= lock_d;
      lsrc_q  <= lsrc_d;
`endif
    end
  end

  assign bus.m_valid = valid_q;
  assign bus.m_data  = data_q;
  assign bus.m_last  = last_q;
  assign bus.m_sel   = sel_q;

endmodule

// File: tb/tb_arb_mux2x1.sv
// Self-checking bench for arb_mux2x1: directed scenarios plus randomized
// traffic against a transaction-level reference model and per-source scoreboard.
module tb_arb_mux2x1;

  localparam int unsigned DW   = 64;
  localparam bit          PRIO = 1'b0;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    logic        sel;
    logic [63:0] data;
    logic        last;
    int          cyc;
  } obs_t;

  logic clk;
  logic rst_n;

  arb_mux2x1_if #(.DATA_W(DW)) bus();

  arb_mux2x1 #(.DATA_W(DW), .PRIO_RST(PRIO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  beat_t q0[$];
  beat_t q1[$];
  beat_t sent0[$];
  beat_t sent1[$];
  obs_t  olog[$];
  obs_t  exp_q[$];

  bit gate0, gate1, rand_gate, rand_ready;
  bit acc0_n, acc1_n;
  bit s1_seen;

  // Reference model: output slot contents, priority owner, open packet owner.
  bit          mdl_mv;
  logic [63:0] mdl_md;
  bit          mdl_ml;
  bit          mdl_ms;
  bit          mdl_ptr;
  bit          mdl_lk;
  bit          mdl_lsrc;
  int          own;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Which source the model says owns the slot this cycle (-1: none).
  always_comb begin
    own = -1;
    if (!mdl_mv || bus.m_ready) begin
      if (bus.s0_valid && bus.s1_valid) own = mdl_ptr ? 1 : 0;
      else if (bus.s0_valid)            own = 0;
      else if (bus.s1_valid)            own = 1;
`ifdef ARB_MUX2X1_LOCK_EN
      if (mdl_lk) own = mdl_lsrc ? 1 : 0;
`endif
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_mv   <= 1'b0;
      mdl_md   <= '0;
      mdl_ml   <= 1'b0;
      mdl_ms   <= 1'b0;
      mdl_ptr  <= PRIO;
      mdl_lk   <= 1'b0;
      mdl_lsrc <= 1'b0;
    end else if ((own == 0 && bus.s0_valid) || (own == 1 && bus.s1_valid)) begin
      mdl_mv <= 1'b1;
      mdl_md <= (own == 1) ? bus.s1_data : bus.s0_data;
      mdl_ml <= (own == 1) ? bus.s1_last : bus.s0_last;
      mdl_ms <= (own == 1);
`ifdef ARB_MUX2X1_LOCK_EN
      if ((own == 1) ? bus.s1_last : bus.s0_last) begin
        mdl_ptr <= (own == 0);
        mdl_lk  <= 1'b0;
      end else begin
        mdl_lk   <= 1'b1;
        mdl_lsrc <= (own == 1);
      end
`else
      mdl_ptr <= (own == 0);
`endif
    end else if (!mdl_mv || bus.m_ready) begin
      mdl_mv <= 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    acc0_n = rst_n && bus.s0_valid && bus.s0_ready;
    acc1_n = rst_n && bus.s1_valid && bus.s1_ready;
    if (rst_n) begin
      if (bus.s1_ready) s1_seen = 1'b1;
      if (bus.m_valid && bus.m_ready)
        olog.push_back('{sel: bus.m_sel, data: bus.m_data, last: bus.m_last, cyc: cyc});
      chk("s0_ready", 64'(bus.s0_ready), 64'(own == 0));
      chk("s1_ready", 64'(bus.s1_ready), 64'(own == 1));
      chk("m_valid",  64'(bus.m_valid),  64'(mdl_mv));
      chk("m_data",   bus.m_data,        mdl_md);
      chk("m_sel",    64'(bus.m_sel),    64'(mdl_ms));
      chk("m_last",   64'(bus.m_last),   64'(mdl_ml));
    end
  end

  // Advance one cycle and drive sources, holding any beat not yet accepted.
  task automatic tick();
    @(posedge clk);
    #1;
    if (acc0_n) void'(q0.pop_front());
    if (acc1_n) void'(q1.pop_front());
    if (rand_gate) begin
      gate0 = ($urandom_range(0, 3) != 0);
      gate1 = ($urandom_range(0, 3) != 0);
    end
    if (!(bus.s0_valid && !acc0_n)) bus.s0_valid = gate0 && (q0.size() > 0);
    if (!(bus.s1_valid && !acc1_n)) bus.s1_valid = gate1 && (q1.size() > 0);
    if (bus.s0_valid) begin
      bus.s0_data = q0[0].data;
      bus.s0_last = q0[0].last;
    end else begin
      bus.s0_data = {$urandom(), $urandom()};
      bus.s0_last = 1'($urandom_range(0, 1));
    end
    if (bus.s1_valid) begin
      bus.s1_data = q1[0].data;
      bus.s1_last = q1[0].last;
    end else begin
      bus.s1_data = {$urandom(), $urandom()};
      bus.s1_last = 1'($urandom_range(0, 1));
    end
    if (rand_ready) bus.m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    rand_gate  = 1'b0;
    rand_ready = 1'b0;
    gate0      = 1'b1;
    gate1      = 1'b1;
    bus.m_ready = 1'b1;
    do begin
      tick();
      n++;
    end while ((q0.size() > 0 || q1.size() > 0 || bus.s0_valid || bus.s1_valid || bus.m_valid)
               && n < budget);
    chk({tag, "_drained"}, 64'(n < budget), 64'd1);
  endtask

  task automatic check_olog(input string tag);
    chk({tag, "_count"}, 64'(olog.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < olog.size(); i++) begin
      chk({tag, "_data"}, olog[i].data, exp_q[i].data);
      chk({tag, "_sel"},  64'(olog[i].sel), 64'(exp_q[i].sel));
      chk({tag, "_last"}, 64'(olog[i].last), 64'(exp_q[i].last));
    end
  endtask

  function automatic obs_t ob(input bit s, input logic [63:0] d, input bit l);
    ob = '{sel: s, data: d, last: l, cyc: 0};
  endfunction

  initial begin
    int gs0;
    int gs1;
    bus.s0_valid = 1'b0; bus.s0_data = '0; bus.s0_last = 1'b0;
    bus.s1_valid = 1'b0; bus.s1_data = '0; bus.s1_last = 1'b0;
    bus.m_ready  = 1'b1;
    gate0 = 1'b0; gate1 = 1'b0; rand_gate = 1'b0; rand_ready = 1'b0;
    acc0_n = 1'b0; acc1_n = 1'b0; s1_seen = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #3;
    chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
    chk("rst_m_data",  bus.m_data,       64'd0);
    chk("rst_m_sel",   64'(bus.m_sel),   64'd0);
    chk("rst_m_last",  64'(bus.m_last),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Contention: alternation starting from the reset priority.
    q0 = '{'{64'hA0, 1'b1}, '{64'hA1, 1'b1}};
    q1 = '{'{64'hB0, 1'b1}, '{64'hB1, 1'b1}};
    olog = {};
    drain("contend", 50);
    exp_q = '{ob(0, 64'hA0, 1), ob(1, 64'hB0, 1), ob(0, 64'hA1, 1), ob(1, 64'hB1, 1)};
    check_olog("contend");

    // Single source on src0 at full rate.
    q0 = '{'{64'h1111, 1'b0}, '{64'h2222, 1'b1}};
    olog = {};
    s1_seen = 1'b0;
    drain("single", 50);
    exp_q = '{ob(0, 64'h1111, 0), ob(0, 64'h2222, 1)};
    check_olog("single");
    if (olog.size() >= 2) chk("single_consec", 64'(olog[1].cyc - olog[0].cyc), 64'd1);
    chk("single_s1_never_ready", 64'(s1_seen), 64'd0);

    // Backpressure: slot held for three cycles, then drained without a bubble.
    bus.m_ready = 1'b0;
    gate1 = 1'b0;
    q0 = '{'{64'hC0C0, 1'b1}, '{64'hC1C1, 1'b1}};
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_m_valid", 64'(bus.m_valid), 64'd1);
      chk("bp_m_data",  bus.m_data, 64'hC0C0);
      chk("bp_m_sel",   64'(bus.m_sel), 64'd0);
      chk("bp_s0_ready", 64'(bus.s0_ready), 64'd0);
      chk("bp_s1_ready", 64'(bus.s1_ready), 64'd0);
      tick();
    end
    bus.m_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_s0_ready", 64'(bus.s0_ready), 64'd1);
    tick();
    @(negedge clk);
    chk("bp_next_valid", 64'(bus.m_valid), 64'd1);
    chk("bp_next_data",  bus.m_data, 64'hC1C1);
    drain("bp", 50);

    // Idle gap: src0 drops valid for two cycles.
    q0 = '{'{64'hD0, 1'b1}, '{64'hD1, 1'b1}};
    gate0 = 1'b1;
    tick();
    gate0 = 1'b0;
    tick();
    @(negedge clk);
    chk("gap_b_valid", 64'(bus.m_valid), 64'd1);
    chk("gap_b_data",  bus.m_data, 64'hD0);
    tick();
    @(negedge clk);
    chk("gap_c_valid", 64'(bus.m_valid), 64'd0);
    chk("gap_c_hold",  bus.m_data, 64'hD0);
    gate0 = 1'b1;
    tick();
    @(negedge clk);
    chk("gap_d_valid", 64'(bus.m_valid), 64'd0);
    tick();
    @(negedge clk);
    chk("gap_e_valid", 64'(bus.m_valid), 64'd1);
    chk("gap_e_data",  bus.m_data, 64'hD1);
    drain("gap", 50);

    // Randomized traffic with per-source order scoreboard.
    q0 = {}; q1 = {};
    for (int i = 0; i < 40; i++) begin
      q0.push_back('{{$urandom(), $urandom()}, (i == 39) || ($urandom_range(0, 2) == 0)});
      q1.push_back('{{$urandom(), $urandom()}, (i == 39) || ($urandom_range(0, 2) == 0)});
    end
    sent0 = q0;
    sent1 = q1;
    olog = {};
    rand_gate = 1'b1;
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    drain("rand", 500);
    gs0 = 0;
    gs1 = 0;
    foreach (olog[i]) begin
      if (olog[i].sel == 1'b0) begin
        if (gs0 < sent0.size()) chk("rand_s0_data", olog[i].data, sent0[gs0].data);
        gs0++;
      end else begin
        if (gs1 < sent1.size()) chk("rand_s1_data", olog[i].data, sent1[gs1].data);
        gs1++;
      end
    end
    chk("rand_s0_count", 64'(gs0), 64'(sent0.size()));
    chk("rand_s1_count", 64'(gs1), 64'(sent1.size()));

    // Reset mid-stream while the output slot is full.
    for (int i = 0; i < 20; i++) begin
      q0.push_back('{{$urandom(), $urandom()}, 1'b1});
      q1.push_back('{{$urandom(), $urandom()}, 1'b1});
    end
    bus.m_ready = 1'b0;
    gate0 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      @(negedge clk);
      if (bus.m_valid) break;
    end
    chk("rst_pre_valid", 64'(bus.m_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_m_valid", 64'(bus.m_valid), 64'd0);
    chk("rst_mid_m_data",  bus.m_data,       64'd0);
    chk("rst_mid_m_sel",   64'(bus.m_sel),   64'd0);
    chk("rst_mid_m_last",  64'(bus.m_last),  64'd0);
    q0 = {}; q1 = {};
    bus.s0_valid = 1'b0;
    bus.s1_valid = 1'b0;
    bus.m_ready  = 1'b1;
    acc0_n = 1'b0;
    acc1_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    acc0_n = 1'b0;
    acc1_n = 1'b0;

    // Packet of three beats on src0 competing with src1.
    q0 = '{'{64'hA0, 1'b0}, '{64'hA1, 1'b0}, '{64'hA2, 1'b1}};
    q1 = '{'{64'hB0, 1'b1}, '{64'hB1, 1'b1}};
    olog = {};
    gate0 = 1'b1;
    gate1 = 1'b1;
    tick();
    @(negedge clk);
    chk("post_rst_grant_s0", 64'(bus.s0_ready), 64'(!PRIO));
    chk("post_rst_grant_s1", 64'(bus.s1_ready), 64'(PRIO));
    drain("pkt", 50);
`ifdef ARB_MUX2X1_LOCK_EN
    exp_q = '{ob(0, 64'hA0, 0), ob(0, 64'hA1, 0), ob(0, 64'hA2, 1),
              ob(1, 64'hB0, 1), ob(1, 64'hB1, 1)};
`else
    exp_q = '{ob(0, 64'hA0, 0), ob(1, 64'hB0, 1), ob(0, 64'hA1, 0),
              ob(1, 64'hB1, 1), ob(0, 64'hA2, 1)};
`endif
    check_olog("pkt");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
